alu_issue_unit: RTL and testbench

Sequential front/back end for the 8-bit combinational ALU (`main_design`: `opcode[1:0]`, `a[7:0]`, `b[7:0]` -> `out[7:0]`). It accepts 8-bit register-register instructions over a valid/ready handshake and reads operands from a 4x8 register file. It drives the ALU ports from registered operands, captures `out`, writes the result back to the destination register and presents it on a valid/ready result port. The ALU is instantiated outside this block; this unit is both its upstream feeder and its downstream consumer.

---
 rtl/alu_issue_pkg.sv | 25 ++
 rtl/regfile4x8.sv | 50 +++++
 rtl/alu_issue_unit.sv | 109 ++++++++++
 tb/tb_alu_issue_unit.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
// Shared types and constants for the ALU issue unit: FSM states, instruction
// field positions, opcode values and datapath sizing.
package alu_issue_pkg;

    localparam int W     = 8;
    localparam int NREGS = 4;

    localparam int OPC_HI = 7;
    localparam int OPC_LO = 6;
    localparam int RD_HI  = 5;
    localparam int RD_LO  = 4;
    localparam int RS1_HI = 3;
    localparam int RS1_LO = 2;
    localparam int RS2_HI = 1;
    localparam int RS2_LO = 0;

    localparam logic [1:0] OP_XOR = 2'b01;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

endpackage

// File: rtl/regfile4x8.sv
// 4x8 register file: two combinational read ports and one merged write path
// where the ALU writeback takes priority over the direct load port.
module regfile4x8
    import alu_issue_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   raddr1_i,
    input  logic [1:0]   raddr2_i,
    output logic [W-1:0] rdata1_o,
    output logic [W-1:0] rdata2_o,
    input  logic         wbEn_i,
    input  logic [1:0]   wbAddr_i,
    input  logic [W-1:0] wbData_i,
    input  logic         ldEn_i,
    input  logic [1:0]   ldAddr_i,
    input  logic [W-1:0] ldData_i
);

    logic [W-1:0] regs_q [NREGS];
    logic [W-1:0] regs_d [NREGS];

    // A load aimed at the register being written back is dropped.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = regs_q[i];
            if (wbEn_i && (wbAddr_i == 2'(i))) begin
                regs_d[i] = wbData_i;
            end else if (ldEn_i && (ldAddr_i == 2'(i))) begin
                regs_d[i] = ldData_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign rdata1_o = regs_q[raddr1_i];
    assign rdata2_o = regs_q[raddr2_i];

endmodule

// File: rtl/alu_issue_unit.sv
// Issue/retire wrapper around an external combinational ALU: accepts
// register-register instructions, feeds the ALU and writes results back.
module alu_issue_unit
    import alu_issue_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid_i,
    input  logic [7:0]   in_instr_i,
    output logic         in_ready_o,
    input  logic         ld_valid_i,
    input  logic [1:0]   ld_addr_i,
    input  logic [W-1:0] ld_data_i,
    output logic [1:0]   alu_opcode_o,
    output logic [W-1:0] alu_a_o,
    output logic [W-1:0] alu_b_o,
    input  logic [W-1:0] alu_out_i,
    output logic         res_valid_o,
    output logic [W-1:0] res_data_o,
    output logic [1:0]   res_rd_o,
    input  logic         res_ready_i
);

    state_t       state_q, state_d;
    logic         readyEn_q;
    logic [1:0]   opcode_q;
    logic [1:0]   rd_q;
    logic [W-1:0] opA_q;
    logic [W-1:0] opB_q;
    logic         resValid_q;
    logic [W-1:0] resData_q;
    logic [W-1:0] rfRdata1;
    logic [W-1:0] rfRdata2;
    logic         accept;

    regfile4x8 u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .raddr1_i (in_instr_i[RS1_HI:RS1_LO]),
        .raddr2_i (in_instr_i[RS2_HI:RS2_LO]),
        .rdata1_o (rfRdata1),
        .rdata2_o (rfRdata2),
        .wbEn_i   (state_q == ISSUE),
        .wbAddr_i (rd_q),
        .wbData_i (alu_out_i),
        .ldEn_i   (ld_valid_i),
        .ldAddr_i (ld_addr_i),
        .ldData_i (ld_data_i)
    );

    // readyEn_q keeps in_ready low while reset is held, even though the
    // state register already sits in IDLE.
    assign in_ready_o = (state_q == IDLE) && readyEn_q;
    assign accept     = in_valid_i && in_ready_o;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = ISSUE;
            ISSUE:   state_d = RESP;
            RESP:    if (res_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            readyEn_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            readyEn_q <= 1'b1;
        end
    end

    // Operands are latched at acceptance and held, so later loads never
    // disturb an instruction already in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opcode_q   <= '0;
            rd_q       <= '0;
            opA_q      <= '0;
            opB_q      <= '0;
            resValid_q <= 1'b0;
            resData_q  <= '0;
        end else begin
            if (accept) begin
                opcode_q <= in_instr_i[OPC_HI:OPC_LO];
                rd_q     <= in_instr_i[RD_HI:RD_LO];
                opA_q    <= rfRdata1;
                opB_q    <= rfRdata2;
            end
            if (state_q == ISSUE) begin
                resValid_q <= 1'b1;
                resData_q  <= alu_out_i;
            end else if ((state_q == RESP) && res_ready_i) begin
                resValid_q <= 1'b0;
            end
        end
    end

    assign alu_opcode_o = opcode_q;
    assign alu_a_o      = opA_q;
    assign alu_b_o      = opB_q;
    assign res_valid_o  = resValid_q;
    assign res_data_o   = resData_q;
    assign res_rd_o     = rd_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Self-checking bench for alu_issue_unit with an external ALU model and a
// register-file reference model kept as a plain array.
module tb_alu_issue_unit;
    import alu_issue_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready, ld_valid, res_valid, res_ready;
    logic [7:0] in_instr, ld_data, alu_a, alu_b, alu_out, res_data;
    logic [1:0] ld_addr, alu_opcode, res_rd;

    int errors = 0;
    int checks = 0;
    logic [7:0] mrf [4];

    typedef struct {
        logic [1:0] opc;
        logic [7:0] a;
        logic [7:0] b;
        logic       busyReady;
        logic       rv;
        logic [7:0] data;
        logic [1:0] rd;
        logic       stable;
        logic       readyAfter;
        logic       rvAfter;
    } obs_t;

    always #5 clk = ~clk;

    alu_issue_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid_i   (in_valid),
        .in_instr_i   (in_instr),
        .in_ready_o   (in_ready),
        .ld_valid_i   (ld_valid),
        .ld_addr_i    (ld_addr),
        .ld_data_i    (ld_data),
        .alu_opcode_o (alu_opcode),
        .alu_a_o      (alu_a),
        .alu_b_o      (alu_b),
        .alu_out_i    (alu_out),
        .res_valid_o  (res_valid),
        .res_data_o   (res_data),
        .res_rd_o     (res_rd),
        .res_ready_i  (res_ready)
    );

    function automatic logic [7:0] aluRef(input logic [1:0] opc, input logic [7:0] a, input logic [7:0] b);
        case (opc)
            2'b00:   return a + b;
            OP_XOR:  return a ^ b;
            2'b10:   return a & b;
            default: return a | b;
        endcase
    endfunction

    assign alu_out = aluRef(alu_opcode, alu_a, alu_b);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doLoad(input logic [1:0] addr, input logic [7:0] data);
        ld_valid = 1'b1;
        ld_addr  = addr;
        ld_data  = data;
        tick();
        ld_valid = 1'b0;
        mrf[addr] = data;
    endtask

    task automatic modelExec(input logic [1:0] opc, input logic [1:0] rd, input logic [1:0] rs1,
                             input logic [1:0] rs2, input logic ldEn, input logic [1:0] ldA,
                             input logic [7:0] ldD, output logic [7:0] expv);
        expv = aluRef(opc, mrf[rs1], mrf[rs2]);
        if (ldEn && ldA != rd) mrf[ldA] = ldD;
        mrf[rd] = expv;
    endtask

    task automatic doInstr(input logic [1:0] opc, input logic [1:0] rd, input logic [1:0] rs1,
                           input logic [1:0] rs2, input logic ldEn, input logic [1:0] ldA,
                           input logic [7:0] ldD, input int hold, output obs_t o);
        in_valid = 1'b1;
        in_instr = {opc, rd, rs1, rs2};
        tick();
        in_valid = 1'b0;
        in_instr = 8'($urandom);
        o.opc = alu_opcode;
        o.a = alu_a;
        o.b = alu_b;
        o.busyReady = in_ready;
        if (ldEn) begin
            ld_valid = 1'b1;
            ld_addr  = ldA;
            ld_data  = ldD;
        end
        tick();
        ld_valid = 1'b0;
        o.rv = res_valid;
        o.data = res_data;
        o.rd = res_rd;
        o.stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (res_valid !== 1'b1 || res_data !== o.data || res_rd !== o.rd || in_ready !== 1'b0)
                o.stable = 1'b0;
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        o.readyAfter = in_ready;
        o.rvAfter = res_valid;
    endtask

    task automatic readReg(input logic [1:0] r, output logic [7:0] v);
        obs_t o;
        doInstr(2'b10, r, r, r, 1'b0, 2'd0, 8'd0, 0, o);
        v = o.a;
    endtask

    task automatic test_reset();
        logic [7:0] v;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_res_valid: got %b expected 0", res_valid); end
        checks++; if (res_data !== 8'h00 || res_rd !== 2'd0) begin errors++; $display("[TB] FAIL reset_res: got %h/%0d expected 00/0", res_data, res_rd); end
        checks++; if (alu_opcode !== 2'd0 || alu_a !== 8'h00 || alu_b !== 8'h00) begin errors++; $display("[TB] FAIL reset_alu: got %b %h %h expected 00 00 00", alu_opcode, alu_a, alu_b); end
        rst_n = 1'b1;
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL release_in_ready: got %b expected 1", in_ready); end
        for (int r = 0; r < 4; r++) begin
            mrf[r] = 8'h00;
            readReg(2'(r), v);
            checks++; if (v !== mrf[r]) begin errors++; $display("[TB] FAIL reset_rf%0d: got %h expected %h", r, v, mrf[r]); end
        end
    endtask

    task automatic test_xor_example();
        obs_t o;
        logic [7:0] e, v;
        doLoad(2'd1, 8'h1F);
        doLoad(2'd2, 8'h11);
        modelExec(OP_XOR, 2'd3, 2'd1, 2'd2, 1'b0, 2'd0, 8'd0, e);
        doInstr(OP_XOR, 2'd3, 2'd1, 2'd2, 1'b0, 2'd0, 8'd0, 0, o);
        checks++; if (o.opc !== 2'b01 || o.a !== 8'h1F || o.b !== 8'h11) begin errors++; $display("[TB] FAIL xor_alu_in: got %b %h %h expected 01 1f 11", o.opc, o.a, o.b); end
        checks++; if (o.busyReady !== 1'b0) begin errors++; $display("[TB] FAIL xor_busy: got in_ready=%b expected 0", o.busyReady); end
        checks++; if (o.rv !== 1'b1 || o.data !== 8'h0E || o.rd !== 2'd3) begin errors++; $display("[TB] FAIL xor_result: got v=%b %h rd=%0d expected v=1 0e rd=3", o.rv, o.data, o.rd); end
        checks++; if (o.readyAfter !== 1'b1 || o.rvAfter !== 1'b0) begin errors++; $display("[TB] FAIL xor_retire: got ready=%b valid=%b expected 1 0", o.readyAfter, o.rvAfter); end
        readReg(2'd3, v);
        checks++; if (v !== 8'h0E || v !== e) begin errors++; $display("[TB] FAIL xor_r3: got %h expected 0e", v); end
    endtask

    task automatic test_self_xor();
        obs_t o;
        logic [7:0] e, v;
        doLoad(2'd0, 8'h01);
        for (int k = 0; k < 2; k++) begin
            modelExec(OP_XOR, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 8'd0, e);
            doInstr(OP_XOR, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 8'd0, 0, o);
            checks++; if (o.data !== 8'h00 || o.data !== e) begin errors++; $display("[TB] FAIL self_xor%0d: got %h expected 00", k, o.data); end
        end
        readReg(2'd0, v);
        checks++; if (v !== 8'h00) begin errors++; $display("[TB] FAIL self_xor_r0: got %h expected 00", v); end
    endtask

    task automatic test_backpressure();
        obs_t o;
        logic [7:0] e;
        doLoad(2'd1, 8'h5A);
        doLoad(2'd2, 8'h3C);
        modelExec(2'b00, 2'd1, 2'd1, 2'd2, 1'b0, 2'd0, 8'd0, e);
        doInstr(2'b00, 2'd1, 2'd1, 2'd2, 1'b0, 2'd0, 8'd0, 5, o);
        checks++; if (o.data !== 8'h96 || o.data !== e) begin errors++; $display("[TB] FAIL bp_data: got %h expected 96", o.data); end
        checks++; if (o.stable !== 1'b1) begin errors++; $display("[TB] FAIL bp_stable: got %b expected 1", o.stable); end
        checks++; if (o.readyAfter !== 1'b1 || o.rvAfter !== 1'b0) begin errors++; $display("[TB] FAIL bp_release: got ready=%b valid=%b expected 1 0", o.readyAfter, o.rvAfter); end
    endtask

    task automatic test_ld_collision();
        obs_t o;
        logic [7:0] e, v;
        doLoad(2'd1, 8'h0F);
        doLoad(2'd2, 8'hF3);
        modelExec(OP_XOR, 2'd3, 2'd1, 2'd2, 1'b1, 2'd3, 8'hAA, e);
        doInstr(OP_XOR, 2'd3, 2'd1, 2'd2, 1'b1, 2'd3, 8'hAA, 0, o);
        readReg(2'd3, v);
        checks++; if (v !== 8'hFC || v !== e) begin errors++; $display("[TB] FAIL coll_same_r3: got %h expected fc", v); end
        modelExec(2'b00, 2'd3, 2'd1, 2'd2, 1'b1, 2'd2, 8'h55, e);
        doInstr(2'b00, 2'd3, 2'd1, 2'd2, 1'b1, 2'd2, 8'h55, 0, o);
        readReg(2'd2, v);
        checks++; if (v !== 8'h55 || v !== mrf[2]) begin errors++; $display("[TB] FAIL coll_other_r2: got %h expected 55", v); end
        readReg(2'd3, v);
        checks++; if (v !== 8'h02 || v !== e) begin errors++; $display("[TB] FAIL coll_other_r3: got %h expected 02", v); end
    endtask

    task automatic test_reset_midop();
        logic [7:0] v;
        doLoad(2'd1, 8'h77);
        in_valid = 1'b1;
        in_instr = {OP_XOR, 2'd2, 2'd1, 2'd3};
        tick();
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        checks++; if (res_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("[TB] FAIL midrst_out: got valid=%b ready=%b expected 0 0", res_valid, in_ready); end
        tick();
        rst_n = 1'b1;
        tick();
        for (int r = 0; r < 4; r++) mrf[r] = 8'h00;
        checks++; if (in_ready !== 1'b1 || res_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_idle: got ready=%b valid=%b expected 1 0", in_ready, res_valid); end
        readReg(2'd2, v);
        checks++; if (v !== mrf[2]) begin errors++; $display("[TB] FAIL midrst_r2: got %h expected %h", v, mrf[2]); end
        readReg(2'd1, v);
        checks++; if (v !== mrf[1]) begin errors++; $display("[TB] FAIL midrst_r1: got %h expected %h", v, mrf[1]); end
    endtask

    task automatic test_random();
        obs_t o;
        logic [1:0] opc, rd, rs1, rs2, la;
        logic [7:0] e, ea, eb, ld;
        logic le;
        for (int it = 0; it < 24; it++) begin
            if ($urandom_range(1, 0) == 1) doLoad(2'($urandom), 8'($urandom));
            opc = 2'($urandom); rd = 2'($urandom); rs1 = 2'($urandom); rs2 = 2'($urandom);
            le = 1'($urandom); la = 2'($urandom); ld = 8'($urandom);
            ea = mrf[rs1];
            eb = mrf[rs2];
            modelExec(opc, rd, rs1, rs2, le, la, ld, e);
            doInstr(opc, rd, rs1, rs2, le, la, ld, int'($urandom_range(2, 0)), o);
            checks++; if (o.opc !== opc || o.a !== ea || o.b !== eb) begin errors++; $display("[TB] FAIL rnd%0d_alu: got %b %h %h expected %b %h %h", it, o.opc, o.a, o.b, opc, ea, eb); end
            checks++; if (o.data !== e || o.rd !== rd) begin errors++; $display("[TB] FAIL rnd%0d_res: got %h rd=%0d expected %h rd=%0d", it, o.data, o.rd, e, rd); end
        end
        for (int r = 0; r < 4; r++) begin
            readReg(2'(r), e);
            checks++; if (e !== mrf[r]) begin errors++; $display("[TB] FAIL rnd_rf%0d: got %h expected %h", r, e, mrf[r]); end
        end
    endtask

    initial begin
        in_valid  = 1'b0;
        in_instr  = 8'h00;
        ld_valid  = 1'b0;
        ld_addr   = 2'd0;
        ld_data   = 8'h00;
        res_ready = 1'b0;
        test_reset();
        test_xor_example();
        test_self_xor();
        test_backpressure();
        test_ld_collision();
        test_reset_midop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
